mem_port_arbiter: RTL and testbench

Sequences the NanoQuarter core's single unified memory port between two requesters:
- instruction fetch, which supplies 32-bit word pairs to the prefetch buffer;
- the data path, which issues 16-bit loads and stores on `memRead`/`memWrite`.

Data accesses have priority, limited by a starvation counter. Fetches can be flushed on taken jumps and branches. The memory side uses a req/ack handshake and tolerates any latency.

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the NanoQuarter unified memory port between instruction
// fetch (32-bit word pairs) and 16-bit data loads/stores over a req/ack memory handshake.
module mem_port_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_req,
   input  logic [31:0] fetch_addr,
   output logic        fetch_valid,
   output logic [31:0] fetch_data,
   input  logic        flush,
   input  logic        dreq_rd,
   input  logic        dreq_wr,
   input  logic [15:0] daddr,
   input  logic [15:0] dwdata,
   output logic        d_done,
   output logic [15:0] drdata,
   output logic        mem_stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_wide,
   output logic [31:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DATA  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t      state_r, state_s;
   logic [3:0]  starve_cnt_r, starve_cnt_s;
   logic        is_wr_r, is_wr_s;
   logic        fetch_valid_r, fetch_valid_s;
   logic        d_done_r, d_done_s;
   logic [31:0] fetch_data_r;
   logic [15:0] drdata_r;
   logic        mem_req_r, mem_we_r, mem_wide_r;
   logic [31:0] mem_addr_r;
   logic [15:0] mem_wdata_r;
   logic        dwant_s, fwant_s, grant_d_s, grant_f_s;

   assign fetch_valid = fetch_valid_r;
   assign fetch_data  = fetch_data_r;
   assign d_done      = d_done_r;
   assign drdata      = drdata_r;
   assign mem_req     = mem_req_r;
   assign mem_we      = mem_we_r;
   assign mem_wide    = mem_wide_r;
   assign mem_addr    = mem_addr_r;
   assign mem_wdata   = mem_wdata_r;
   assign mem_stall   = (dreq_rd | dreq_wr) & ~d_done_r;

   // Next-state, grant and done-pulse decode; a requester is masked in its own done cycle.
   always_comb begin
      state_s       = state_r;
      starve_cnt_s  = starve_cnt_r;
      grant_d_s     = 1'b0;
      grant_f_s     = 1'b0;
      fetch_valid_s = 1'b0;
      d_done_s      = 1'b0;
      dwant_s       = (dreq_rd | dreq_wr) & ~d_done_r;
      fwant_s       = fetch_req & ~flush & ~fetch_valid_r;
      case (state_r)
         IDLE: begin
            if (dwant_s && (!fwant_s || (starve_cnt_r < STARVE_LIM))) begin
               state_s   = DATA;
               grant_d_s = 1'b1;
               if (fwant_s) begin
                  starve_cnt_s = (starve_cnt_r == 4'd15) ? 4'd15 : starve_cnt_r + 4'd1;
               end else begin
                  starve_cnt_s = 4'd0;
               end
            end else if (fwant_s) begin
               state_s      = FETCH;
               grant_f_s    = 1'b1;
               starve_cnt_s = 4'd0;
            end else begin
               state_s = IDLE;
            end
         end
         FETCH: begin
            if (mem_ack) begin
               state_s       = IDLE;
               fetch_valid_s = ~flush;
            end else if (flush) begin
               state_s = DRAIN;
            end else begin
               state_s = FETCH;
            end
         end
         DATA: begin
            if (mem_ack) begin
               state_s  = IDLE;
               d_done_s = 1'b1;
            end else begin
               state_s = DATA;
            end
         end
         DRAIN: begin
            if (mem_ack) begin
               state_s = IDLE;
            end else begin
               state_s = DRAIN;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      is_wr_s = grant_d_s ? dreq_wr : is_wr_r;
   end

   // State, latched request fields and registered port outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= IDLE;
         starve_cnt_r  <= 4'd0;
         is_wr_r       <= 1'b0;
         fetch_valid_r <= 1'b0;
         d_done_r      <= 1'b0;
         fetch_data_r  <= 32'd0;
         drdata_r      <= 16'd0;
         mem_req_r     <= 1'b0;
         mem_we_r      <= 1'b0;
         mem_wide_r    <= 1'b0;
         mem_addr_r    <= 32'd0;
         mem_wdata_r   <= 16'd0;
      end else begin
         state_r       <= state_s;
         starve_cnt_r  <= starve_cnt_s;
         is_wr_r       <= is_wr_s;
         fetch_valid_r <= fetch_valid_s;
         d_done_r      <= d_done_s;
         if (fetch_valid_s) begin
            fetch_data_r <= mem_rdata;
         end
         if (d_done_s && !is_wr_r) begin
            drdata_r <= mem_rdata[15:0];
         end
         if (grant_d_s) begin
            mem_addr_r  <= {16'd0, daddr};
            mem_wdata_r <= dwdata;
         end else if (grant_f_s) begin
            mem_addr_r <= fetch_addr;
         end
         mem_req_r  <= (state_s != IDLE);
         mem_we_r   <= (state_s == DATA) && is_wr_s;
         mem_wide_r <= (state_s == FETCH) || (state_s == DRAIN);
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic, all compared each
// cycle against a transaction-level reference model of the arbiter.
module tb_mem_port_arbiter;

   localparam int SMAX = 4;
   localparam int O_IDLE = 0, O_FETCH = 1, O_DATA = 2, O_DRAIN = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_req, flush, dreq_rd, dreq_wr, mem_ack;
   logic [31:0] fetch_addr, mem_rdata;
   logic [15:0] daddr, dwdata;
   logic        fetch_valid, d_done, mem_stall, mem_req, mem_we, mem_wide;
   logic [31:0] fetch_data, mem_addr;
   logic [15:0] drdata, mem_wdata;

   int checks = 0;
   int errors = 0;

   // reference model state
   int          m_own, m_cnt;
   logic        m_fv, m_dd, m_wr;
   logic [31:0] m_fdata, m_addr;
   logic [15:0] m_drdata, m_wdata;

   int          ack_cnt;
   logic        flush_prev;

   mem_port_arbiter #(.STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst(rst),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_valid(fetch_valid), .fetch_data(fetch_data),
      .flush(flush),
      .dreq_rd(dreq_rd), .dreq_wr(dreq_wr), .daddr(daddr), .dwdata(dwdata),
      .d_done(d_done), .drdata(drdata), .mem_stall(mem_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_wide(mem_wide),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_own = O_IDLE; m_cnt = 0; m_fv = 1'b0; m_dd = 1'b0; m_wr = 1'b0;
      m_fdata = 32'd0; m_addr = 32'd0; m_drdata = 16'd0; m_wdata = 16'd0;
   endtask

   // One clock edge of the arbiter rules, applied to the inputs present at that edge.
   task automatic model_step();
      logic nfv, ndd;
      bit   dw, fw;
      if (rst) begin
         model_reset();
      end else begin
         dw  = (dreq_rd | dreq_wr) && !m_dd;
         fw  = fetch_req && !flush && !m_fv;
         nfv = 1'b0;
         ndd = 1'b0;
         if (m_own == O_IDLE) begin
            if (dw && (!fw || m_cnt < SMAX)) begin
               m_own   = O_DATA;
               m_addr  = {16'd0, daddr};
               m_wdata = dwdata;
               m_wr    = dreq_wr;
               m_cnt   = fw ? ((m_cnt < 15) ? m_cnt + 1 : 15) : 0;
            end else if (fw) begin
               m_own  = O_FETCH;
               m_addr = fetch_addr;
               m_cnt  = 0;
            end
         end else if (mem_ack) begin
            if (m_own == O_FETCH && !flush) begin
               nfv     = 1'b1;
               m_fdata = mem_rdata;
            end
            if (m_own == O_DATA) begin
               ndd = 1'b1;
               if (!m_wr) m_drdata = mem_rdata[15:0];
            end
            m_own = O_IDLE;
         end else if (m_own == O_FETCH && flush) begin
            m_own = O_DRAIN;
         end
         m_fv = nfv;
         m_dd = ndd;
      end
   endtask

   task automatic compare();
      chk("fetch_valid", 32'(fetch_valid), 32'(m_fv));
      chk("fetch_data", fetch_data, m_fdata);
      chk("d_done", 32'(d_done), 32'(m_dd));
      chk("drdata", 32'(drdata), 32'(m_drdata));
      chk("mem_req", 32'(mem_req), 32'(m_own != O_IDLE));
      chk("mem_we", 32'(mem_we), 32'(m_own == O_DATA && m_wr));
      if (m_own != O_DRAIN) chk("mem_wide", 32'(mem_wide), 32'(m_own == O_FETCH));
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      chk("mem_stall", 32'(mem_stall), 32'((dreq_rd | dreq_wr) & ~m_dd));
      chk("done_excl", 32'(fetch_valid & d_done), 32'd0);
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic drive_random();
      int r;
      flush_prev = flush;
      if (rst) begin
         rst = 1'b0;
      end else if ($urandom_range(0, 599) == 0) begin
         rst = 1'b1; dreq_rd = 1'b0; dreq_wr = 1'b0; fetch_req = 1'b0; flush = 1'b0;
      end else begin
         if (!(dreq_rd | dreq_wr) || m_dd) begin
            r = $urandom_range(0, 5);
            dreq_rd = (r == 3 || r == 5);
            dreq_wr = (r == 4 || r == 5);
         end
         if (!fetch_req || m_fv || flush_prev) fetch_req = ($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 7) == 0);
      end
      daddr      = 16'($urandom);
      dwdata     = 16'($urandom);
      fetch_addr = $urandom;
      mem_rdata  = $urandom;
      if (m_own != O_IDLE) begin
         if (ack_cnt == 0) begin
            mem_ack = 1'b1;
         end else begin
            mem_ack = 1'b0;
            ack_cnt--;
         end
      end else begin
         mem_ack = 1'($urandom_range(0, 1));
         ack_cnt = $urandom_range(0, 3);
      end
   endtask

   initial begin
      int   nreq, nfv, nd, ng;
      logic prev_req;
      logic [4:0] g;
      rst = 1'b1; fetch_req = 1'b0; flush = 1'b0; dreq_rd = 1'b0; dreq_wr = 1'b0;
      mem_ack = 1'b0; fetch_addr = 32'd0; mem_rdata = 32'd0; daddr = 16'd0; dwdata = 16'd0;
      ack_cnt = 0; flush_prev = 1'b0;
      model_reset();
      step();
      step();
      rst = 1'b0;

      // zero-wait load
      dreq_rd = 1'b1; daddr = 16'h0040; mem_rdata = 32'h0000_BEEF; mem_ack = 1'b1;
      #1 chk("zw_stall_pre", 32'(mem_stall), 32'd1);
      step();
      chk("zw_addr", mem_addr, 32'h40);
      chk("zw_wide", 32'(mem_wide), 32'd0);
      chk("zw_stall_wait", 32'(mem_stall), 32'd1);
      step();
      chk("zw_done", 32'(d_done), 32'd1);
      chk("zw_drdata", 32'(drdata), 32'h0000_BEEF);
      chk("zw_stall_done", 32'(mem_stall), 32'd0);
      dreq_rd = 1'b0; mem_ack = 1'b0;
      step();
      chk("zw_done_once", 32'(d_done), 32'd0);

      // fetch with 3 wait states
      fetch_req = 1'b1; fetch_addr = 32'h10; mem_rdata = 32'h1234_5678;
      nreq = 0; nfv = 0;
      for (int i = 1; i <= 6; i++) begin
         step();
         nreq += int'(mem_req);
         nfv  += int'(fetch_valid);
         if (i == 1) chk("f3_addr", mem_addr, 32'h10);
         if (mem_req) chk("f3_wide", 32'(mem_wide), 32'd1);
         if (fetch_valid) begin
            chk("f3_data", fetch_data, 32'h1234_5678);
            fetch_req = 1'b0;
         end
         mem_ack = (i == 4);
      end
      chk("f3_req_cycles", 32'(nreq), 32'd4);
      chk("f3_valid_count", 32'(nfv), 32'd1);

      // starvation: both held; flush pulses in data done cycles keep fetch from slipping in
      fetch_req = 1'b1; fetch_addr = 32'h20; dreq_rd = 1'b1; daddr = 16'h0080; mem_ack = 1'b1;
      g = 5'd0; ng = 0; prev_req = mem_req;
      for (int i = 0; i < 40 && ng < 5; i++) begin
         step();
         if (mem_req && !prev_req) begin
            g = {g[3:0], mem_wide};
            ng++;
         end
         prev_req = mem_req;
         flush = m_dd;
      end
      chk("starve_grants", 32'(ng), 32'd5);
      chk("starve_order", 32'(g), 32'b00001);
      flush = 1'b0;
      step();
      fetch_req = 1'b0; dreq_rd = 1'b0; mem_ack = 1'b0;
      step();
      step();

      // flush in FETCH one cycle before a delayed ack
      fetch_req = 1'b1; fetch_addr = 32'h100; mem_rdata = 32'hDEAD_0001;
      step();
      chk("fl_addr", mem_addr, 32'h100);
      step();
      flush = 1'b1; fetch_addr = 32'h200;
      step();
      chk("fl_drain_req", 32'(mem_req), 32'd1);
      chk("fl_drain_addr", mem_addr, 32'h100);
      chk("fl_no_valid", 32'(fetch_valid), 32'd0);
      flush = 1'b0; mem_ack = 1'b1;
      step();
      chk("fl_idle_req", 32'(mem_req), 32'd0);
      chk("fl_idle_valid", 32'(fetch_valid), 32'd0);
      mem_ack = 1'b0;
      step();
      chk("fl_regrant_req", 32'(mem_req), 32'd1);
      chk("fl_regrant_addr", mem_addr, 32'h200);
      mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
      step();
      chk("fl_valid", 32'(fetch_valid), 32'd1);
      chk("fl_data", fetch_data, 32'hCAFE_F00D);
      fetch_req = 1'b0; mem_ack = 1'b0;
      step();

      // simultaneous read and write
      dreq_rd = 1'b1; dreq_wr = 1'b1; daddr = 16'h0022; dwdata = 16'hA5A5; mem_ack = 1'b1;
      nd = 0;
      for (int i = 1; i <= 5; i++) begin
         step();
         if (i == 1) begin
            chk("rw_we", 32'(mem_we), 32'd1);
            chk("rw_wdata", 32'(mem_wdata), 32'h0000_A5A5);
            daddr = 16'hFFFF; dwdata = 16'h0000;
         end
         nd += int'(d_done);
         if (d_done) begin
            dreq_rd = 1'b0; dreq_wr = 1'b0;
         end
      end
      chk("rw_done_count", 32'(nd), 32'd1);
      chk("rw_addr_held", mem_addr, 32'h22);
      mem_ack = 1'b0;

      // reset mid-DATA with ack pending
      dreq_rd = 1'b1; daddr = 16'h0055;
      step();
      step();
      mem_ack = 1'b1;
      #2 rst = 1'b1; dreq_rd = 1'b0;
      #1;
      chk("rst_fetch_data", fetch_data, 32'd0);
      chk("rst_drdata", 32'(drdata), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_misc", 32'({fetch_valid, d_done, mem_we, mem_wide, mem_stall}), 32'd0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_no_done", 32'(d_done), 32'd0);
      end
      mem_ack = 1'b0;
      step();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         drive_random();
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "timeout");
   end

endmodule
